capture_probe: RTL and testbench

Parametrised on-chip trace capture core: the successor to the fixed-width debug capture used on the encoder path (interval time, encoder count, debounce count). It stores qualified samples of a DATA_W probe bus into a circular buffer with configurable pre-trigger depth. The trigger is multi-bit, maskable and mode-selectable. After capture, the buffer streams out oldest-first over a valid/ready port to the host-side reader (UART/JTAG bridge).

---
 rtl/capture_probe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_capture_probe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_probe.sv
// capture_probe: qualified trace capture into a circular buffer with pre-trigger depth,
// maskable multi-mode trigger and oldest-first valid/ready readout.
// Optional feature: define CAPTURE_PROBE_TIMESTAMP_EN to store a TS_W timestamp above each sample.
module capture_probe #(
  parameter int DATA_W   = 27,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64,
  parameter int TRIG_W   = 4,
  parameter int TS_W     = 16,
`ifdef CAPTURE_PROBE_TIMESTAMP_EN
  localparam bit TS_EN   = 1'b1,
`else
  localparam bit TS_EN   = 1'b0,
`endif
  localparam int OUT_W   = DATA_W + (TS_EN ? TS_W : 0)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              sample_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [1:0]        trig_mode_i,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [OUT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_N  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - 1 - PRE_TRIG);
  localparam logic [CW-1:0] RD_N   = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]     issue_q, issue_d;
  logic [TRIG_W-1:0] prev_trig_q, prev_trig_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [OUT_W-1:0]  rd_data_q, rd_data_d;

  logic [OUT_W-1:0]  mem [DEPTH];
  logic [OUT_W-1:0]  ram_q;
  logic [OUT_W-1:0]  wdata;
  logic [TRIG_W-1:0] cond;
  logic              hit, we, re, adv, go_read, finish;

`ifdef CAPTURE_PROBE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  assign wdata = {ts_q, data_i};
`else
  assign wdata = data_i;
`endif

  // Edge conditions compare against the previous qualified sample, not the previous clock.
  always_comb begin
    case (trig_mode_i)
      2'b00:   cond = trig_i;
      2'b01:   cond = trig_i & ~prev_trig_q;
      2'b10:   cond = ~trig_i & prev_trig_q;
      default: cond = trig_i ^ prev_trig_q;
    endcase
  end

  assign hit = (trig_mask_i == '0) || (|(trig_mask_i & cond));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    cnt_d       = cnt_q;
    issue_d     = issue_q;
    prev_trig_d = prev_trig_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    we          = 1'b0;
    re          = 1'b0;
    go_read     = 1'b0;
    finish      = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    adv         = !rd_valid_q || rd_ready_i;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d     = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          prev_trig_d = '0;
        end
      end
      S_PRE: begin
        if (sample_en_i) begin
          we          = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          prev_trig_d = trig_i;
          cnt_d       = cnt_inc;
          if (cnt_inc == PRE_N) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (sample_en_i) begin
          we          = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          prev_trig_d = trig_i;
          if (hit) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
            if (POST_N == '0) go_read = 1'b1;
            else              state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (sample_en_i) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == POST_N) go_read = 1'b1;
        end
      end
      S_READ: begin
        // RAM output register and output register advance together; a stall freezes both.
        if (adv) begin
          rd_valid_d = ram_vld_q;
          rd_last_d  = ram_last_q;
          if (ram_vld_q) rd_data_d = ram_q;
          ram_vld_d  = 1'b0;
          ram_last_d = 1'b0;
          if (issue_q != RD_N) begin
            re         = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            issue_d    = issue_q + 1'b1;
            ram_vld_d  = 1'b1;
            ram_last_d = (issue_q == RD_N - 1'b1);
          end
        end
        finish = rd_valid_q && rd_ready_i && rd_last_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_read) begin
      state_d  = S_READ;
      done_d   = 1'b1;
      rd_ptr_d = trig_addr_d - PRE_A;
      issue_d  = '0;
    end

    if (abort_i || finish) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      trig_addr_d = '0;
      cnt_d       = '0;
      issue_d     = '0;
      prev_trig_d = '0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      ram_vld_d   = 1'b0;
      ram_last_d  = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      rd_data_d   = '0;
      we          = 1'b0;
      re          = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      issue_q     <= '0;
      prev_trig_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      issue_q     <= issue_d;
      prev_trig_q <= prev_trig_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: the buffer has no reset so it maps onto block RAM; every slot is rewritten before a readout.
  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q] <= wdata;
    if (re) ram_q <= mem[rd_ptr_q];
  end

  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_last_o   = rd_last_q;

endmodule

// File: tb/tb_capture_probe.sv
// Directed bench for capture_probe: table of capture scenarios plus abort/reset sequences.
// DATA_W=8, DEPTH=16, PRE_TRIG=4, TRIG_W=2; timestamp field checked when the macro is defined.
module tb_capture_probe;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int TRIG_W   = 2;
  localparam int TS_W     = 4;
`ifdef CAPTURE_PROBE_TIMESTAMP_EN
  localparam int OUT_W = DATA_W + TS_W;
`else
  localparam int OUT_W = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              sample_en_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [TRIG_W-1:0] trig_i = '0;
  logic [TRIG_W-1:0] trig_mask_i = '0;
  logic [1:0]        trig_mode_i = '0;
  logic [2:0]        state_o;
  logic              triggered_o;
  logic              done_o;
  logic [OUT_W-1:0]  rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i = 1'b0;
  logic              rd_last_o;

  always #5 clk = ~clk;

  capture_probe #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .TRIG_W(TRIG_W), .TS_W(TS_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .arm_i(arm_i), .abort_i(abort_i),
    .sample_en_i(sample_en_i), .data_i(data_i), .trig_i(trig_i),
    .trig_mask_i(trig_mask_i), .trig_mode_i(trig_mode_i), .state_o(state_o),
    .triggered_o(triggered_o), .done_o(done_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o)
  );

  // One capture scenario: trig_i is trig_lo before sample value sw_at and trig_hi from it on.
  typedef struct {
    string      name;
    logic [1:0] mask;
    logic [1:0] mode;
    logic [1:0] trig_lo;
    logic [1:0] trig_hi;
    int         sw_at;
    bit         even_only;
    bit         bp;
    int         first;
    int         step;
  } vec_t;

  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dval;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    data_i      = 8'(dval);
    trig_i      = (dval >= v.sw_at) ? v.trig_hi : v.trig_lo;
    sample_en_i = v.even_only ? (dval % 2 == 0) : 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int               trig_seen, n, words, k;
    bit               stall;
    logic [OUT_W-1:0] held;
    logic             held_last;
    logic [OUT_W-1:0] got [DEPTH];
    logic             lst [DEPTH];
    logic [TS_W-1:0]  ts_diff;

    trig_mask_i = v.mask;
    trig_mode_i = v.mode;
    rd_ready_i  = 1'b0;
    dval        = 0;
    drive(v);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    check({v.name, "_armed"}, 32'(state_o), 32'd1);

    trig_seen = -1;
    n = 0;
    while (!done_o && n < 200) begin
      dval++;
      drive(v);
      tick();
      n++;
      if (triggered_o && trig_seen < 0) trig_seen = dval;
    end
    if (!done_o) begin
      check({v.name, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({v.name, "_trig_sample"}, 32'(trig_seen), 32'(v.first + PRE_TRIG * v.step));
    sample_en_i = 1'b0;

    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_valid_o && n < 10);
    check({v.name, "_valid_latency"}, 32'(n), 32'd2);

    words = 0;
    k = 0;
    while (words < DEPTH && k < 100) begin
      rd_ready_i = v.bp ? (k % 2 == 0) : 1'b1;
      if (rd_valid_o && rd_ready_i) begin
        got[words] = rd_data_o;
        lst[words] = rd_last_o;
        words++;
      end
      stall     = rd_valid_o && !rd_ready_i;
      held      = rd_data_o;
      held_last = rd_last_o;
      tick();
      k++;
      if (stall) check({v.name, "_stall_hold"}, 32'({rd_valid_o, rd_last_o, rd_data_o}),
                       32'({1'b1, held_last, held}));
    end
    rd_ready_i = 1'b0;
    check({v.name, "_word_count"}, 32'(words), 32'(DEPTH));
    if (words != DEPTH) return;
    check({v.name, "_end_idle"}, 32'({state_o, triggered_o, done_o, rd_valid_o}), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s_word%0d", v.name, i), 32'(got[i][DATA_W-1:0]),
            32'(8'(v.first + i * v.step)));
      check($sformatf("%s_last%0d", v.name, i), 32'(lst[i]), 32'(i == DEPTH - 1));
`ifdef CAPTURE_PROBE_TIMESTAMP_EN
      if (i > 0) begin
        ts_diff = got[i][OUT_W-1:DATA_W] - got[i-1][OUT_W-1:DATA_W];
        check($sformatf("%s_ts%0d", v.name, i), 32'(ts_diff), 32'(4'(v.step)));
      end
`else
      ts_diff = '0;
`endif
    end
  endtask

  initial begin
    int   n;
    vec_t v;

    vecs[0] = '{"basic_rise",    2'b01, 2'b01, 2'b00, 2'b01, 20, 1'b0, 1'b0, 16, 1};
    vecs[1] = '{"backpressure",  2'b01, 2'b01, 2'b00, 2'b01, 20, 1'b0, 1'b1, 16, 1};
    vecs[2] = '{"prefill_level", 2'b10, 2'b00, 2'b10, 2'b10,  0, 1'b0, 1'b0,  1, 1};
    vecs[3] = '{"forced_even",   2'b00, 2'b00, 2'b00, 2'b00,  0, 1'b1, 1'b0,  2, 2};
    vecs[4] = '{"falling",       2'b01, 2'b10, 2'b01, 2'b00, 12, 1'b0, 1'b0,  8, 1};
    vecs[5] = '{"any_edge_b1",   2'b10, 2'b11, 2'b00, 2'b10,  9, 1'b0, 1'b1,  5, 1};
    vecs[6] = '{"masked_level",  2'b01, 2'b00, 2'b10, 2'b11, 15, 1'b0, 1'b0, 11, 1};

    tick();
    tick();
    check("reset_outputs", 32'({state_o, triggered_o, done_o, rd_valid_o, rd_last_o, rd_data_o}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("reset_release_idle", 32'(state_o), 32'd0);

    for (int i = 0; i < 7; i++) apply(vecs[i]);

    // Abort has priority over arm, and clears a capture in progress.
    trig_mask_i = '0;
    trig_mode_i = 2'b00;
    sample_en_i = 1'b1;
    rd_ready_i  = 1'b1;
    arm_i = 1'b1;
    abort_i = 1'b1;
    tick();
    arm_i = 1'b0;
    abort_i = 1'b0;
    check("abort_beats_arm", 32'(state_o), 32'd0);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    n = 0;
    while (state_o != 3'd3 && n < 50) begin
      tick();
      n++;
    end
    check("reach_post", 32'(state_o), 32'd3);
    check("post_triggered", 32'(triggered_o), 32'd1);
    abort_i = 1'b1;
    arm_i = 1'b1;
    tick();
    abort_i = 1'b0;
    arm_i = 1'b0;
    check("abort_in_post", 32'({state_o, triggered_o, done_o, rd_valid_o}), 32'd0);

    // Asynchronous reset in the middle of a readout.
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    n = 0;
    while (!rd_valid_o && n < 60) begin
      tick();
      n++;
    end
    check("reach_read", 32'({state_o, rd_valid_o}), 32'({3'd4, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("reset_in_read", 32'({state_o, triggered_o, done_o, rd_valid_o}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    v = vecs[0];
    v.name = "rearm_after_reset";
    apply(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
